// File: rtl/dcpu16_pkg.sv
// rtl/dcpu16_pkg.sv - state and grant encodings shared by the dcpu16 bus arbiter
package dcpu16_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSF = 2'd1,
      ARB_BUSG = 2'd2
   } arb_state_e;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_F    = 2'b01;
   localparam logic [1:0] GNT_G    = 2'b10;

endpackage

// File: rtl/dcpu16_tmo.sv
// rtl/dcpu16_tmo.sv - saturating watchdog counter; expire flags the last allowed wait cycle
module dcpu16_tmo #(
   parameter int TMO = 16,
   parameter int TW  = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic expire
);

   localparam logic [TW-1:0] LIM = (TMO == 0) ? '0 : TW'(TMO - 1);
   localparam logic          ENA = (TMO != 0);

   logic [TW-1:0] r_cnt;

   // Holding at LIM keeps the count from wrapping if the owner lingers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (run && (r_cnt != LIM)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expire = ENA && run && (r_cnt == LIM);

endmodule

// File: rtl/dcpu16_busarb.sv
// rtl/dcpu16_busarb.sv - round-robin F/G bus arbiter in front of one synchronous memory port
module dcpu16_busarb
   import dcpu16_pkg::*;
#(
   parameter int TMO = 16,
   parameter int TW  = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] f_adr,
   input  logic [15:0] f_dto,
   input  logic        f_stb,
   input  logic        f_wre,
   output logic        f_ack,
   output logic        f_err,
   output logic [15:0] f_dti,
   input  logic [15:0] g_adr,
   input  logic [15:0] g_dto,
   input  logic        g_stb,
   input  logic        g_wre,
   output logic        g_ack,
   output logic        g_err,
   output logic [15:0] g_dti,
   output logic [15:0] m_adr,
   output logic [15:0] m_dto,
   output logic        m_stb,
   output logic        m_wre,
   input  logic [15:0] m_dti,
   input  logic        m_ack,
   output logic [1:0]  gnt
);

   arb_state_e  r_state;
   arb_state_e  w_next;
   logic [15:0] r_m_adr;
   logic [15:0] r_m_dto;
   logic        r_m_stb;
   logic        r_m_wre;
   logic [1:0]  r_gnt;
   logic        r_last;

   logic w_busy;
   logic w_tmo_clr;
   logic w_tmo_run;
   logic w_expire;
   logic w_take_f;
   logic w_take_g;
   logic w_done;

   assign w_busy    = (r_state != ARB_IDLE);
   assign w_tmo_clr = !w_busy;
   assign w_tmo_run = w_busy && !m_ack;

   dcpu16_tmo #(
      .TMO (TMO),
      .TW  (TW)
   ) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_tmo_clr),
      .run    (w_tmo_run),
      .expire (w_expire)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // r_last = 1 means G was served last, so a tie goes to F.
   always_comb begin
      w_next   = r_state;
      w_take_f = 1'b0;
      w_take_g = 1'b0;
      w_done   = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (f_stb && (!g_stb || r_last)) begin
               w_next   = ARB_BUSF;
               w_take_f = 1'b1;
            end else if (g_stb) begin
               w_next   = ARB_BUSG;
               w_take_g = 1'b1;
            end
         end
         ARB_BUSF, ARB_BUSG: begin
            if (m_ack || w_expire) begin
               w_next = ARB_IDLE;
               w_done = 1'b1;
            end
         end
         default: w_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_m_adr <= '0;
         r_m_dto <= '0;
         r_m_stb <= 1'b0;
         r_m_wre <= 1'b0;
         r_gnt   <= GNT_NONE;
         r_last  <= 1'b1;
      end else if (w_take_f) begin
         r_m_adr <= f_adr;
         r_m_dto <= f_dto;
         r_m_wre <= f_wre;
         r_m_stb <= 1'b1;
         r_gnt   <= GNT_F;
      end else if (w_take_g) begin
         r_m_adr <= g_adr;
         r_m_dto <= g_dto;
         r_m_wre <= g_wre;
         r_m_stb <= 1'b1;
         r_gnt   <= GNT_G;
      end else if (w_done) begin
         r_m_stb <= 1'b0;
         r_gnt   <= GNT_NONE;
         r_last  <= (r_state == ARB_BUSG);
      end
   end

   // Gating with rst keeps an aborted transfer from acking during reset.
   assign f_ack = rst && (r_state == ARB_BUSF) && w_done;
   assign g_ack = rst && (r_state == ARB_BUSG) && w_done;
   assign f_err = rst && (r_state == ARB_BUSF) && w_expire && !m_ack;
   assign g_err = rst && (r_state == ARB_BUSG) && w_expire && !m_ack;

   assign f_dti = m_dti;
   assign g_dti = m_dti;
   assign m_adr = r_m_adr;
   assign m_dto = r_m_dto;
   assign m_stb = r_m_stb;
   assign m_wre = r_m_wre;
   assign gnt   = r_gnt;

endmodule

// File: tb/tb_dcpu16_busarb.sv
// tb/tb_dcpu16_busarb.sv - self-checking bench for dcpu16_busarb with a transaction-level model
module tb_dcpu16_busarb;
   import dcpu16_pkg::*;

   localparam int TMO_P = 4;

   logic        clk;
   logic        rst;
   logic [15:0] f_adr, f_dto, f_dti, g_adr, g_dto, g_dti;
   logic        f_stb, f_wre, f_ack, f_err, g_stb, g_wre, g_ack, g_err;
   logic [15:0] m_adr, m_dto, m_dti;
   logic        m_stb, m_wre, m_ack;
   logic [1:0]  gnt;

   int errors;
   int checks;
   logic tb_last;

   dcpu16_busarb #(.TMO(TMO_P), .TW(3)) dut (
      .clk(clk), .rst(rst),
      .f_adr(f_adr), .f_dto(f_dto), .f_stb(f_stb), .f_wre(f_wre),
      .f_ack(f_ack), .f_err(f_err), .f_dti(f_dti),
      .g_adr(g_adr), .g_dto(g_dto), .g_stb(g_stb), .g_wre(g_wre),
      .g_ack(g_ack), .g_err(g_err), .g_dti(g_dti),
      .m_adr(m_adr), .m_dto(m_dto), .m_stb(m_stb), .m_wre(m_wre),
      .m_dti(m_dti), .m_ack(m_ack), .gnt(gnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle_inputs();
      f_stb = 1'b0; f_wre = 1'b0; f_adr = '0; f_dto = '0;
      g_stb = 1'b0; g_wre = 1'b0; g_adr = '0; g_dto = '0;
      m_ack = 1'b0; m_dti = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      m_ack = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({m_stb, m_wre, m_adr, m_dto, gnt} !== 35'd0) begin
         errors++;
         $display("FAIL reset_regs: got stb=%b wre=%b adr=%h dto=%h gnt=%b expected all zero", m_stb, m_wre, m_adr, m_dto, gnt);
      end
      checks++;
      if ({f_ack, g_ack, f_err, g_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_acks: got %b expected 0000", {f_ack, g_ack, f_err, g_err});
      end
      @(negedge clk);
      rst = 1'b1;
      m_ack = 1'b0;
      tb_last = 1'b1;
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      f_stb = 1'b1; f_wre = 1'b1; f_adr = 16'h0010; f_dto = 16'h1234;
      g_stb = 1'b1; g_wre = 1'b0; g_adr = 16'h0020; g_dto = 16'h0000;
      @(negedge clk);
      m_ack = 1'b1;
      #1;
      checks++;
      if ({gnt, m_adr, m_dto, m_wre} !== {GNT_F, 16'h0010, 16'h1234, 1'b1}) begin
         errors++;
         $display("FAIL sim_first: got gnt=%b adr=%h dto=%h wre=%b expected gnt=01 adr=0010 dto=1234 wre=1", gnt, m_adr, m_dto, m_wre);
      end
      checks++;
      if ({f_ack, g_ack} !== 2'b10) begin
         errors++;
         $display("FAIL sim_first_ack: got f/g ack=%b expected 10", {f_ack, g_ack});
      end
      @(negedge clk);
      f_stb = 1'b0; m_ack = 1'b0;
      #1;
      checks++;
      if ({m_stb, gnt} !== 3'b000) begin
         errors++;
         $display("FAIL sim_turnaround: got stb=%b gnt=%b expected 0 00", m_stb, gnt);
      end
      @(negedge clk);
      m_ack = 1'b1;
      #1;
      checks++;
      if ({gnt, m_adr, m_wre} !== {GNT_G, 16'h0020, 1'b0}) begin
         errors++;
         $display("FAIL sim_second: got gnt=%b adr=%h wre=%b expected 10 0020 0", gnt, m_adr, m_wre);
      end
      checks++;
      if ({f_ack, g_ack} !== 2'b01) begin
         errors++;
         $display("FAIL sim_second_ack: got f/g ack=%b expected 01", {f_ack, g_ack});
      end
      @(negedge clk);
      idle_inputs();
      tb_last = 1'b1;
   endtask

   task automatic test_f_read();
      int pulses;
      int gacks;
      pulses = 0;
      gacks  = 0;
      @(negedge clk);
      f_stb = 1'b1; f_wre = 1'b0; f_adr = 16'h0100;
      #1;
      checks++;
      if (m_stb !== 1'b0) begin
         errors++;
         $display("FAIL fread_latency: got m_stb=%b expected 0", m_stb);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         m_ack = (i == 1);
         m_dti = (i == 1) ? 16'hBEEF : 16'h0000;
         if (i == 2) f_stb = 1'b0;
         #1;
         if (f_ack) pulses++;
         if (g_ack) gacks++;
         if (i == 0) begin
            checks++;
            if ({m_stb, m_adr, gnt} !== {1'b1, 16'h0100, GNT_F}) begin
               errors++;
               $display("FAIL fread_bus: got stb=%b adr=%h gnt=%b expected 1 0100 01", m_stb, m_adr, gnt);
            end
         end
         if (i == 1) begin
            checks++;
            if ({f_ack, f_dti} !== {1'b1, 16'hBEEF}) begin
               errors++;
               $display("FAIL fread_data: got ack=%b dti=%h expected 1 beef", f_ack, f_dti);
            end
         end
      end
      checks++;
      if (pulses != 1 || gacks != 0) begin
         errors++;
         $display("FAIL fread_pulses: got f_ack=%0d g_ack=%0d expected 1 0", pulses, gacks);
      end
      idle_inputs();
      tb_last = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      int got;
      int cyc;
      exp_g = tb_last ? GNT_F : GNT_G;
      got = 0;
      cyc = 0;
      @(negedge clk);
      f_stb = 1'b1; f_adr = 16'h0A00; g_stb = 1'b1; g_adr = 16'h0B00;
      while (got < 6 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         m_ack = m_stb;
         #1;
         if (m_stb) begin
            checks++;
            if (gnt !== exp_g || m_adr !== ((exp_g == GNT_F) ? 16'h0A00 : 16'h0B00)) begin
               errors++;
               $display("FAIL rr_grant%0d: got gnt=%b adr=%h expected gnt=%b", got, gnt, m_adr, exp_g);
            end
            got++;
            exp_g = (exp_g == GNT_F) ? GNT_G : GNT_F;
         end
      end
      checks++;
      if (got != 6) begin
         errors++;
         $display("FAIL rr_count: got %0d grants expected 6", got);
      end
      @(negedge clk);
      idle_inputs();
      tb_last = (exp_g == GNT_F);
   endtask

   task automatic test_watchdog();
      int hi;
      hi = 0;
      @(negedge clk);
      g_stb = 1'b1; g_wre = 1'b0; g_adr = 16'h0300;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         if (m_stb) hi++;
         checks++;
         if ({g_ack, g_err, f_ack} !== ((i == 3) ? 3'b110 : 3'b000)) begin
            errors++;
            $display("FAIL wd_cycle%0d: got g_ack/g_err/f_ack=%b expected %b", i, {g_ack, g_err, f_ack}, (i == 3) ? 3'b110 : 3'b000);
         end
      end
      @(negedge clk);
      g_stb = 1'b0;
      #1;
      checks++;
      if (m_stb !== 1'b0 || hi != 4) begin
         errors++;
         $display("FAIL wd_stb_len: got m_stb=%b high=%0d expected 0 4", m_stb, hi);
      end
      @(negedge clk);
      @(negedge clk);
      m_ack = 1'b1;
      #1;
      checks++;
      if ({f_ack, g_ack, g_err, m_stb} !== 4'b0000) begin
         errors++;
         $display("FAIL wd_late_ack: got %b expected 0000", {f_ack, g_ack, g_err, m_stb});
      end
      @(negedge clk);
      idle_inputs();
      tb_last = 1'b1;
   endtask

   task automatic test_ack_at_limit();
      @(negedge clk);
      f_stb = 1'b1; f_adr = 16'h0400;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         m_ack = (i == 3);
         #1;
         checks++;
         if ({f_ack, f_err} !== ((i == 3) ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL limit_cycle%0d: got ack/err=%b expected %b", i, {f_ack, f_err}, (i == 3) ? 2'b10 : 2'b00);
         end
      end
      @(negedge clk);
      idle_inputs();
      tb_last = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      f_stb = 1'b1; f_adr = 16'h0042;
      @(negedge clk);
      #1;
      checks++;
      if ({m_stb, m_adr} !== {1'b1, 16'h0042}) begin
         errors++;
         $display("FAIL rmid_busy: got stb=%b adr=%h expected 1 0042", m_stb, m_adr);
      end
      @(negedge clk);
      rst = 1'b0;
      m_ack = 1'b1;
      #1;
      checks++;
      if ({f_ack, f_err, g_ack, g_err} !== 4'b0000) begin
         errors++;
         $display("FAIL rmid_ack_in_reset: got %b expected 0000", {f_ack, f_err, g_ack, g_err});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({m_stb, m_adr, gnt, f_ack} !== 20'd0) begin
         errors++;
         $display("FAIL rmid_cleared: got stb=%b adr=%h gnt=%b ack=%b expected zero", m_stb, m_adr, gnt, f_ack);
      end
      @(negedge clk);
      rst = 1'b1; m_ack = 1'b0;
      f_stb = 1'b1; f_adr = 16'h0050; g_stb = 1'b1; g_adr = 16'h0060;
      @(negedge clk);
      m_ack = 1'b1;
      #1;
      checks++;
      if ({gnt, m_adr} !== {GNT_F, 16'h0050}) begin
         errors++;
         $display("FAIL rmid_tie: got gnt=%b adr=%h expected 01 0050", gnt, m_adr);
      end
      @(negedge clk);
      f_stb = 1'b0; m_ack = 1'b0;
      @(negedge clk);
      m_ack = 1'b1;
      #1;
      checks++;
      if ({gnt, g_ack} !== {GNT_G, 1'b1}) begin
         errors++;
         $display("FAIL rmid_second: got gnt=%b g_ack=%b expected 10 1", gnt, g_ack);
      end
      @(negedge clk);
      idle_inputs();
      tb_last = 1'b1;
   endtask

   task automatic test_random();
      int mo, k, lat, lim, s_age, s_lat;
      logic m_last, f_pend, g_pend, done, e_err, ea_f, ea_g, e_wre;
      logic [15:0] e_adr, e_dto;
      mo = 0; k = 0; lat = 0; s_age = 0; s_lat = 0;
      m_last = tb_last; f_pend = 1'b0; g_pend = 1'b0;
      e_adr = '0; e_dto = '0; e_wre = 1'b0;
      for (int cyc = 0; cyc < 1200; cyc++) begin
         @(negedge clk);
         if (cyc < 1000) begin
            if (!f_pend && $urandom_range(0, 2) == 0) begin
               f_pend = 1'b1; f_adr = 16'($urandom); f_dto = 16'($urandom); f_wre = 1'($urandom);
            end
            if (!g_pend && $urandom_range(0, 2) == 0) begin
               g_pend = 1'b1; g_adr = 16'($urandom); g_dto = 16'($urandom); g_wre = 1'($urandom);
            end
         end
         f_stb = f_pend;
         g_stb = g_pend;
         if (m_stb) begin
            if (s_age == 0) s_lat = $urandom_range(0, 5);
            m_ack = (s_age == s_lat);
         end else begin
            m_ack = ($urandom_range(0, 3) == 0);
         end
         m_dti = 16'($urandom);
         #1;
         if (mo == 0) begin
            checks++;
            if (m_stb !== 1'b0 || gnt !== GNT_NONE) begin
               errors++;
               $display("FAIL rnd_idle_bus cyc%0d: got stb=%b gnt=%b expected 0 00", cyc, m_stb, gnt);
            end
            checks++;
            if ({f_ack, g_ack, f_err, g_err} !== 4'b0000) begin
               errors++;
               $display("FAIL rnd_idle_ack cyc%0d: got %b expected 0000", cyc, {f_ack, g_ack, f_err, g_err});
            end
            if (f_stb && (!g_stb || m_last)) begin
               mo = 1; e_adr = f_adr; e_dto = f_dto; e_wre = f_wre;
            end else if (g_stb) begin
               mo = 2; e_adr = g_adr; e_dto = g_dto; e_wre = g_wre;
            end
            k = 0;
         end else begin
            if (k == 0) lat = s_lat;
            checks++;
            if (m_stb !== 1'b1 || gnt !== ((mo == 1) ? GNT_F : GNT_G)) begin
               errors++;
               $display("FAIL rnd_owner cyc%0d: got stb=%b gnt=%b expected 1 %b", cyc, m_stb, gnt, (mo == 1) ? GNT_F : GNT_G);
            end
            checks++;
            if ({m_adr, m_dto, m_wre} !== {e_adr, e_dto, e_wre}) begin
               errors++;
               $display("FAIL rnd_fields cyc%0d: got %h/%h/%b expected %h/%h/%b", cyc, m_adr, m_dto, m_wre, e_adr, e_dto, e_wre);
            end
            lim   = (lat < TMO_P - 1) ? lat : TMO_P - 1;
            done  = (k == lim);
            e_err = done && (lat > TMO_P - 1);
            ea_f  = (mo == 1) && done;
            ea_g  = (mo == 2) && done;
            checks++;
            if ({f_ack, f_err, g_ack, g_err} !== {ea_f, ea_f && e_err, ea_g, ea_g && e_err}) begin
               errors++;
               $display("FAIL rnd_ack cyc%0d: got %b expected %b", cyc, {f_ack, f_err, g_ack, g_err}, {ea_f, ea_f && e_err, ea_g, ea_g && e_err});
            end
            if (done) begin
               checks++;
               if (((mo == 1) ? f_dti : g_dti) !== m_dti) begin
                  errors++;
                  $display("FAIL rnd_dti cyc%0d: got %h expected %h", cyc, (mo == 1) ? f_dti : g_dti, m_dti);
               end
               m_last = (mo == 2);
               mo = 0;
            end else begin
               k++;
            end
         end
         if (f_ack) f_pend = 1'b0;
         if (g_ack) g_pend = 1'b0;
         s_age = m_stb ? s_age + 1 : 0;
         if (cyc >= 1000 && mo == 0 && !f_pend && !g_pend) break;
      end
      checks++;
      if (mo != 0 || f_pend || g_pend) begin
         errors++;
         $display("FAIL rnd_drain: got owner=%0d pend=%b%b expected 0 00", mo, f_pend, g_pend);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      tb_last = 1'b1;
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_simultaneous();
      test_f_read();
      test_round_robin();
      test_watchdog();
      test_ack_at_limit();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
